// File: rtl/length_arbiter.sv
// length_arbiter
// Round-robin scheduler that shares one pipelined vec3 length unit between
// NUM_REQ requesters. Each issue is tagged with its requester index in an
// in-order tag FIFO, and each returned length is routed to that requester's
// response holding register. A requester may have one request outstanding.
module length_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TAG_W      = $clog2(NUM_REQ),
    parameter int WORD_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][3*WORD_WIDTH-1:0]  req_vec,
    output logic [NUM_REQ-1:0]                    resp_valid,
    input  logic [NUM_REQ-1:0]                    resp_ready,
    output logic [NUM_REQ-1:0][WORD_WIDTH-1:0]    resp_length,
    output logic [3*WORD_WIDTH-1:0]               len_vec,
    output logic                                  len_valid_in,
    input  logic [WORD_WIDTH-1:0]                 len_length,
    input  logic                                  len_valid_out,
    output logic                                  busy,
    output logic                                  err_orphan
);

    localparam int               CNT_W       = $clog2(NUM_REQ + 1);
    localparam logic [TAG_W:0]   NUM_REQ_EXT = (TAG_W + 1)'(NUM_REQ);
    localparam logic [TAG_W-1:0] LAST_IDX    = TAG_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] accept;
    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   grant_idx;
    logic               grant_found;
    logic [TAG_W:0]     idx_sum;

    logic [TAG_W-1:0]   tag_mem [NUM_REQ];
    logic [TAG_W-1:0]   wr_ptr;
    logic [TAG_W-1:0]   rd_ptr;
    logic [TAG_W-1:0]   head_tag;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    assign eligible   = req_valid & ~pending;
    assign accept     = req_valid & req_ready;
    assign push       = |accept;
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = len_valid_out & ~fifo_empty;
    assign head_tag   = tag_mem[rd_ptr];
    assign busy       = |pending;

    // Search for the first eligible requester at or after rr_ptr, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_sum = {1'b0, rr_ptr} + (TAG_W + 1)'(k);
            if (idx_sum >= NUM_REQ_EXT) begin
                idx_sum = idx_sum - NUM_REQ_EXT;
            end
            if (!grant_found && eligible[idx_sum[TAG_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx_sum[TAG_W-1:0];
            end
        end
    end

    // One-hot grant; forced to zero while reset is asserted so it drops
    // without waiting for a clock edge.
    always_comb begin
        req_ready = '0;
        if (grant_found && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Issue stage: forward the winning vector and advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            len_vec      <= '0;
            len_valid_in <= 1'b0;
        end else begin
            len_valid_in <= push;
            if (push) begin
                len_vec <= req_vec[grant_idx];
                rr_ptr  <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Tag FIFO: occupancy is bounded by NUM_REQ because of the pending rule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= grant_idx;
                wr_ptr          <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    // Response routing, pending tracking and the sticky orphan-result flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= '0;
            resp_valid  <= '0;
            resp_length <= '0;
            err_orphan  <= 1'b0;
        end else begin
            pending <= (pending & ~(resp_valid & resp_ready)) | accept;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pop && head_tag == TAG_W'(i)) begin
                    resp_valid[i]  <= 1'b1;
                    resp_length[i] <= len_length;
                end else if (resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
            if (len_valid_out && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_length_arbiter.sv
// Testbench for length_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (grant search, pending set,
// queue of results with due cycles).
module tb_length_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int L = 10;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [N-1:0]           req_valid = '0;
    logic [N-1:0]           req_ready;
    logic [N-1:0][3*W-1:0]  req_vec = '0;
    logic [N-1:0]           resp_valid;
    logic [N-1:0]           resp_ready = '0;
    logic [N-1:0][W-1:0]    resp_length;
    logic [3*W-1:0]         len_vec;
    logic                   len_valid_in;
    logic [W-1:0]           len_length;
    logic                   len_valid_out;
    logic                   busy;
    logic                   err_orphan;

    int checks = 0;
    int failures = 0;

    logic [L-1:0] pipe_v = '0;
    logic [W-1:0] pipe_d [L];

    length_arbiter #(.NUM_REQ(N), .WORD_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_length(resp_length),
        .len_vec(len_vec), .len_valid_in(len_valid_in),
        .len_length(len_length), .len_valid_out(len_valid_out),
        .busy(busy), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    function automatic logic [3*W-1:0] mkvec(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] z);
        return {z, y, x};
    endfunction

    // Exact Euclidean length of a Q8.24 vec3, result in Q8.24.
    function automatic logic [W-1:0] vlen(input logic [3*W-1:0] v);
        longint sx, sy, sz;
        logic [63:0] ax, ay, az, s, t64;
        logic [W-1:0] r, t;
        sx = longint'($signed(v[W-1:0]));
        sy = longint'($signed(v[2*W-1:W]));
        sz = longint'($signed(v[3*W-1:2*W]));
        ax = (sx < 0) ? 64'(-sx) : 64'(sx);
        ay = (sy < 0) ? 64'(-sy) : 64'(sy);
        az = (sz < 0) ? 64'(-sz) : 64'(sz);
        s = ax * ax + ay * ay + az * az;
        r = '0;
        for (int b = W - 1; b >= 0; b--) begin
            t = r | (W'(1) << b);
            t64 = {32'd0, t};
            if (t64 * t64 <= s) r = t;
        end
        return r;
    endfunction

    function automatic logic [3*W-1:0] rndvec();
        return mkvec(W'($signed($urandom) >>> 2), W'($signed($urandom) >>> 2),
                     W'($signed($urandom) >>> 2));
    endfunction

    // Length unit stand-in: fixed latency L, never stalls, not reset by the DUT.
    always @(posedge clk) begin
        pipe_v <= {pipe_v[L-2:0], len_valid_in};
        pipe_d[0] <= vlen(len_vec);
        for (int k = 1; k < L; k++) pipe_d[k] <= pipe_d[k-1];
    end
    assign len_valid_out = pipe_v[L-1];
    assign len_length    = pipe_d[L-1];

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '1;
        resp_ready = '0;
        #1;
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        @(negedge clk); #1;
        checks++; if (resp_valid !== '0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0000", resp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (len_valid_in !== 1'b0) begin failures++; $display("FAIL reset_len_valid_in got=%b exp=0", len_valid_in); end
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL reset_err_orphan got=%b exp=0", err_orphan); end
        checks++; if (len_vec !== '0) begin failures++; $display("FAIL reset_len_vec got=%h exp=0", len_vec); end
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready_held got=%b exp=0000", req_ready); end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3*W-1:0] v;
        int n;
        v = mkvec(32'h0300_0000, 32'h0400_0000, 32'h0);
        @(negedge clk);
        req_vec[1] = v;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b exp=0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (len_valid_in !== 1'b1) begin failures++; $display("FAIL single_len_valid_in got=%b exp=1", len_valid_in); end
        checks++; if (len_vec !== v) begin failures++; $display("FAIL single_len_vec got=%h exp=%h", len_vec, v); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        @(negedge clk); #1;
        n = 2;
        checks++; if (len_valid_in !== 1'b0) begin failures++; $display("FAIL single_len_valid_in_pulse got=%b exp=0", len_valid_in); end
        while (!resp_valid[1] && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        checks++; if (n != 12) begin failures++; $display("FAIL single_resp_latency got=%0d exp=11 cycles after len_valid_in", n - 1); end
        checks++; if (resp_length[1] !== 32'h0500_0000) begin failures++; $display("FAIL single_resp_length got=%h exp=05000000", resp_length[1]); end
        checks++; if (resp_valid !== 4'b0010) begin failures++; $display("FAIL single_resp_route got=%b exp=0010", resp_valid); end
        resp_ready = 4'b0010;
        @(negedge clk);
        resp_ready = '0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
        checks++; if (resp_valid !== '0) begin failures++; $display("FAIL single_consume got=%b exp=0000", resp_valid); end
    endtask

    task automatic test_all_four();
        logic [N-1:0] e;
        logic [W-1:0] exp_len;
        int n;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) req_vec[i] = mkvec(W'((i + 1) * 3) << 24, W'((i + 1) * 4) << 24, '0);
        req_valid = '1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            e = '0;
            e[i] = 1'b1;
            checks++; if (req_ready !== e) begin failures++; $display("FAIL all4_grant_order step=%0d got=%b exp=%b", i, req_ready, e); end
            @(negedge clk); #1;
        end
        req_valid = '0;
        n = 0;
        while (resp_valid !== '1 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        checks++; if (resp_valid !== '1) begin failures++; $display("FAIL all4_resp_valid got=%b exp=1111", resp_valid); end
        for (int i = 0; i < N; i++) begin
            exp_len = W'((i + 1) * 5) << 24;
            checks++; if (resp_length[i] !== exp_len) begin failures++; $display("FAIL all4_resp_length idx=%0d got=%h exp=%h", i, resp_length[i], exp_len); end
        end
        resp_ready = '1;
        @(negedge clk);
        resp_ready = '0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL all4_busy got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        int n;
        @(negedge clk);
        req_vec[2] = rndvec();
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rr_grant2 got=%b exp=0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n = 0;
        while (!resp_valid[2] && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        checks++; if (resp_valid[2] !== 1'b1) begin failures++; $display("FAIL rr_resp2 got=%b exp=1", resp_valid[2]); end
        resp_ready = 4'b0100;
        @(negedge clk);
        resp_ready = '0;
        req_vec[0] = rndvec();
        req_vec[3] = rndvec();
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rr_first3 got=%b exp=1000", req_ready); end
        @(negedge clk); #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rr_then0 got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n = 0;
        while (resp_valid !== 4'b1001 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        checks++; if (resp_valid !== 4'b1001) begin failures++; $display("FAIL rr_resp got=%b exp=1001", resp_valid); end
        checks++; if (resp_length[3] !== vlen(req_vec[3])) begin failures++; $display("FAIL rr_len3 got=%h exp=%h", resp_length[3], vlen(req_vec[3])); end
        resp_ready = 4'b1001;
        @(negedge clk);
        resp_ready = '0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_busy got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_len;
        int n, bad_rdy, bad_len;
        @(negedge clk);
        req_vec[0] = rndvec();
        exp_len = vlen(req_vec[0]);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_grant got=%b exp=0001", req_ready); end
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!resp_valid[0] && n < 40);
        checks++; if (resp_valid[0] !== 1'b1) begin failures++; $display("FAIL bp_resp got=%b exp=1", resp_valid[0]); end
        bad_rdy = 0;
        bad_len = 0;
        repeat (20) begin
            @(negedge clk);
            req_vec[0] = rndvec();
            #1;
            if (req_ready[0] !== 1'b0) bad_rdy++;
            if (resp_length[0] !== exp_len || resp_valid[0] !== 1'b1) bad_len++;
        end
        checks++; if (bad_rdy != 0) begin failures++; $display("FAIL bp_ready_held cycles_granted=%0d exp=0", bad_rdy); end
        checks++; if (bad_len != 0) begin failures++; $display("FAIL bp_length_stable cycles_changed=%0d exp=0", bad_len); end
        resp_ready = 4'b0001;
        @(negedge clk);
        resp_ready = '0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_regrant got=%b exp=0001", req_ready); end
        checks++; if (resp_valid[0] !== 1'b0) begin failures++; $display("FAIL bp_consumed got=%b exp=0", resp_valid[0]); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (len_valid_in !== 1'b1 || len_vec !== req_vec[0]) begin failures++; $display("FAIL bp_reissue got=%b/%h exp=1/%h", len_valid_in, len_vec, req_vec[0]); end
        n = 0;
        while (!resp_valid[0] && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        resp_ready = 4'b0001;
        @(negedge clk);
        resp_ready = '0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_midflight();
        int bad_rv;
        @(negedge clk);
        req_vec[1] = rndvec();
        req_vec[2] = rndvec();
        req_valid = 4'b0110;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL mf_grant1 got=%b exp=0010", req_ready); end
        @(negedge clk); #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL mf_grant2 got=%b exp=0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        req_valid = '1;
        #1;
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL mf_req_ready got=%b exp=0000", req_ready); end
        checks++; if (resp_valid !== '0) begin failures++; $display("FAIL mf_resp_valid got=%b exp=0000", resp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mf_busy got=%b exp=0", busy); end
        checks++; if (len_valid_in !== 1'b0) begin failures++; $display("FAIL mf_len_valid_in got=%b exp=0", len_valid_in); end
        checks++; if (len_vec !== '0) begin failures++; $display("FAIL mf_len_vec got=%h exp=0", len_vec); end
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL mf_err_orphan got=%b exp=0", err_orphan); end
        for (int i = 0; i < N; i++) begin
            checks++; if (resp_length[i] !== '0) begin failures++; $display("FAIL mf_resp_length idx=%0d got=%h exp=0", i, resp_length[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        #1;
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL mf_orphan_early got=%b exp=0", err_orphan); end
        bad_rv = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (resp_valid !== '0) bad_rv++;
        end
        checks++; if (bad_rv != 0) begin failures++; $display("FAIL mf_no_resp cycles_with_resp=%0d exp=0", bad_rv); end
        checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL mf_orphan_set got=%b exp=1", err_orphan); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL mf_orphan_rst got=%b exp=0", err_orphan); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [N-1:0]   pend_m = '0;
        logic [N-1:0]   rv_m = '0;
        logic [N-1:0]   exp_rdy;
        logic [W-1:0]   rl_m [N];
        logic [3*W-1:0] lv_m = '0;
        logic           lvi_m = 1'b0;
        int             q_tag[$];
        logic [W-1:0]   q_len[$];
        int             q_due[$];
        int             rr_m = 0, grants = 0, coinc = 0, cyc = 0;
        int             g, idx, t, due;
        bit             popped, drained;
        for (int i = 0; i < N; i++) rl_m[i] = '0;
        drained = 1'b0;
        while (!drained && cyc < 3000) begin
            @(negedge clk);
            req_valid = (grants < 100) ? N'($urandom) : '0;
            for (int i = 0; i < N; i++) begin
                req_vec[i] = rndvec();
                resp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            #1;
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (rr_m + k) % N;
                if (g < 0 && req_valid[idx] && !pend_m[idx]) g = idx;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rnd_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
            checks++; if (resp_valid !== rv_m) begin failures++; $display("FAIL rnd_resp_valid cyc=%0d got=%b exp=%b", cyc, resp_valid, rv_m); end
            checks++; if (busy !== (|pend_m)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, |pend_m); end
            checks++; if (len_valid_in !== lvi_m) begin failures++; $display("FAIL rnd_len_valid_in cyc=%0d got=%b exp=%b", cyc, len_valid_in, lvi_m); end
            if (lvi_m) begin
                checks++; if (len_vec !== lv_m) begin failures++; $display("FAIL rnd_len_vec cyc=%0d got=%h exp=%h", cyc, len_vec, lv_m); end
            end
            for (int i = 0; i < N; i++) begin
                if (rv_m[i]) begin
                    checks++; if (resp_length[i] !== rl_m[i]) begin failures++; $display("FAIL rnd_resp_length cyc=%0d idx=%0d got=%h exp=%h", cyc, i, resp_length[i], rl_m[i]); end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rv_m[i] && resp_ready[i]) pend_m[i] = 1'b0;
                if (resp_ready[i]) rv_m[i] = 1'b0;
            end
            popped = 1'b0;
            if (q_due.size() > 0 && q_due[0] == cyc + 1) begin
                t = q_tag.pop_front();
                rv_m[t] = 1'b1;
                rl_m[t] = q_len.pop_front();
                due = q_due.pop_front();
                popped = 1'b1;
            end
            lvi_m = 1'b0;
            if (g >= 0) begin
                pend_m[g] = 1'b1;
                rr_m = (g + 1) % N;
                q_tag.push_back(g);
                q_len.push_back(vlen(req_vec[g]));
                q_due.push_back(cyc + 1 + L + 1);
                lvi_m = 1'b1;
                lv_m = req_vec[g];
                grants++;
                if (popped) coinc++;
            end
            cyc++;
            drained = (grants >= 100) && (q_due.size() == 0) && (rv_m == '0) && (pend_m == '0);
        end
        checks++; if (!drained) begin failures++; $display("FAIL rnd_timeout grants=%0d cycles=%0d exp=drained", grants, cyc); end
        checks++; if (coinc == 0) begin failures++; $display("FAIL rnd_push_pop_overlap got=%0d exp=nonzero", coinc); end
        @(negedge clk);
        resp_ready = '0;
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== '0) begin failures++; $display("FAIL rnd_final got=%b/%b exp=0/0000", busy, resp_valid); end
        checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL rnd_orphan got=%b exp=0", err_orphan); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/length_arbiter.md
# length_arbiter

Round-robin scheduler that shares one pipelined vec3 length unit between `NUM_REQ` ray-marcher requesters (normal estimation, step-size evaluation, etc.). It accepts one vec3 per cycle from the winning requester and issues it to the length unit. It tags each issue with the requester index and routes each returned length into that requester's response holding register. Each requester may have at most one request outstanding.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TAG_W`, `$clog2(NUM_REQ)`: width of the requester index.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `[NUM_REQ]`  requester i presents `req_vec[i]`.
- `req_ready`  out  `[NUM_REQ]`  one-hot-or-zero grant; transfer on `req_valid[i] & req_ready[i]`.
- `req_vec`  in  `[NUM_REQ]` x vec3  Q8.24 vector per requester.
- `resp_valid`  out  `[NUM_REQ]`  `resp_length[i]` holds a result.
- `resp_ready`  in  `[NUM_REQ]`  requester i consumes its result.
- `resp_length`  out  `[NUM_REQ]` x `WORD_WIDTH`  Q8.24 length per requester.
- `len_vec`  out  vec3  operand to the shared length unit.
- `len_valid_in`  out  1  issue strobe to the length unit.
- `len_length`  in  `WORD_WIDTH`  length unit result.
- `len_valid_out`  in  1  length unit result strobe. Results are in order, one per issue, and the unit never stalls.
- `busy`  out  1  any request pending or in flight.
- `err_orphan`  out  1  sticky: `len_valid_out` arrived with an empty tag FIFO.

## Operation
- `pending[i]` is set when requester i's request is accepted. It is cleared on the `resp_valid[i] & resp_ready[i]` handshake.
- Eligibility: requester i is eligible when `req_valid[i] & ~pending[i]`.
- Grant: `req_ready` is combinational from `req_valid`, `pending` and `rr_ptr`. It goes to the first eligible index at or after `rr_ptr`, searching with wrap-around. At most one grant per cycle.
- On acceptance of index g:
  - `rr_ptr <= (g+1) mod NUM_REQ`.
  - `len_vec <= req_vec[g]`; `len_valid_in <= 1` for exactly one cycle.
  - g is pushed into the tag FIFO, which has depth `NUM_REQ`.
- With no acceptance, `len_valid_in <= 0` and `len_vec` holds its value.
- Tag FIFO: it cannot overflow, because the `pending` rule limits occupancy to `NUM_REQ`.
  - On `len_valid_out`, pop the head tag t and register `resp_length[t] <= len_length`, `resp_valid[t] <= 1`.
  - Push and pop in the same cycle are both performed and occupancy is unchanged.
- Orphan result: `len_valid_out` with an empty FIFO sets `err_orphan`. The result is dropped and no response register changes. `err_orphan` clears only on `rst`.
- Response consumption: `resp_valid[i]` clears on the edge where `resp_ready[i]` is high. `pending[i]` clears on the same edge. `resp_length[i]` holds its value until overwritten.
- `busy = |pending`.
- Reset, including mid-operation:
  - Cleared: `req_ready`, `resp_valid`, `pending`, `len_valid_in`, `busy`, `err_orphan`, tag FIFO, `rr_ptr`.
  - Set to 0: `len_vec`, `resp_length`.
  - Results still inside the length unit after reset raise `err_orphan` when they emerge. This is the intended diagnostic.

## Timing
- Edge E0 is the request handshake. `len_valid_in` is high during cycle E0+1.
- If the length unit latency is L, `len_valid_out` occurs at E0+1+L. `resp_valid[t]` rises on the following edge.
- Minimum reissue spacing for the same requester: the `resp_ready` handshake edge, then one cycle, then the grant. `pending` is cleared by a register, so the requester is eligible in the cycle after the handshake.
- Throughput: one issue per cycle across different requesters.
- Fairness: each eligible requester is granted within `NUM_REQ` cycles of becoming eligible.
- `resp_ready` may be held high permanently. `resp_valid[i]` then stays high for exactly one cycle per result.

## Test plan
- Single request: requester 1 sends (3.0, 4.0, 0.0) = 0x03000000, 0x04000000, 0; length unit model has L=10.
  - `len_valid_in` is high exactly one cycle after the handshake.
  - `resp_valid[1]` rises 11 cycles after `len_valid_in` with `resp_length[1]` = 0x05000000.
  - `busy` falls after `resp_ready[1]`.
- All four requesters request at reset exit: grants go 0, 1, 2, 3 on consecutive cycles, and responses are routed to matching indices with distinct lengths.
- Round-robin: after a grant to 2, requesters 0 and 3 assert together; 3 is granted first, then 0.
- Backpressure: `resp_ready[0]` is held low for 20 cycles while `req_valid[0]` stays high.
  - `req_ready[0]` stays 0 and `resp_length[0]` is stable.
  - Requester 0 is granted again one cycle after the consume handshake.
- Reset mid-flight: assert `rst` with 2 requests in flight.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - The two stale `len_valid_out` pulses set `err_orphan`, and no `resp_valid` rises.
- Simultaneous push and pop: an issue lands in the same cycle as a return. FIFO occupancy is unchanged and the tags stay in order across 100 random transactions, checked against a scoreboard.
